ssg_scan_rx: RTL and testbench

SSG_SCAN_RX -- requirements
Module: ssg_scan_rx

---
 rtl/ssg_scan_rx.sv | 112 +++++++++++
 tb/tb_ssg_scan_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ssg_scan_rx.sv
// Seven-segment scan receiver: recovers a 4-digit frame from a multiplexed LED drive.
// Optional macro SSG_SCAN_RX_ERRCNT_EN adds a saturating err_count output.
module ssg_scan_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic        valid,
  output logic        frame_err
`ifdef SSG_SCAN_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  logic [10:0] sync1, sync2, prev;
  logic [7:0]  cnt;
  logic [15:0] shadow;
  logic [3:0]  cap, bad;
  logic [3:0]  sel_oh;
  logic        sel_ok, same, capture;
  logic [3:0]  dec_val;
  logic        dec_bad;
  logic [3:0]  cap_nxt, bad_nxt;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1111110: seg_decode = {1'b0, 4'h0};
      7'b0110000: seg_decode = {1'b0, 4'h1};
      7'b1101101: seg_decode = {1'b0, 4'h2};
      7'b1111001: seg_decode = {1'b0, 4'h3};
      7'b0110011: seg_decode = {1'b0, 4'h4};
      7'b1011011: seg_decode = {1'b0, 4'h5};
      7'b0011111: seg_decode = {1'b0, 4'h6};
      7'b1110000: seg_decode = {1'b0, 4'h7};
      7'b1111111: seg_decode = {1'b0, 4'h8};
      7'b1110011: seg_decode = {1'b0, 4'h9};
      default:    seg_decode = {1'b1, 4'hF};
    endcase
  endfunction

  // Exactly one enable low selects a digit; anything else is a blanking gap.
  always_comb begin
    sel_oh = 4'b0000;
    sel_ok = 1'b1;
    case (sync2[10:7])
      4'b1110: sel_oh = 4'b0001;
      4'b1101: sel_oh = 4'b0010;
      4'b1011: sel_oh = 4'b0100;
      4'b0111: sel_oh = 4'b1000;
      default: sel_ok = 1'b0;
    endcase
  end

  assign same    = (sync2 == prev);
  // Fires on the sample that brings the counter to STABLE_CYCLES-1; saturation prevents a repeat.
  assign capture = sel_ok && same && (cnt == 8'(STABLE_CYCLES - 2));
  assign {dec_bad, dec_val} = seg_decode(~sync2[6:0]);

  // A completing frame clears the masks first so a coincident capture lands in the new frame.
  always_comb begin
    cap_nxt = (cap == 4'hF) ? 4'h0 : cap;
    bad_nxt = (cap == 4'hF) ? 4'h0 : bad;
    if (capture) begin
      cap_nxt = cap_nxt | sel_oh;
      bad_nxt = (bad_nxt & ~sel_oh) | (dec_bad ? sel_oh : 4'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '1;
      sync2     <= '1;
      prev      <= '1;
      cnt       <= '0;
      shadow    <= '0;
      cap       <= '0;
      bad       <= '0;
      digits    <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef SSG_SCAN_RX_ERRCNT_EN
      err_count <= '0;
`endif
    end else begin
      sync1 <= {an_n, seg_n};
      sync2 <= sync1;
      prev  <= sync2;
      if (!sel_ok || !same)
        cnt <= '0;
      else if (cnt < 8'(STABLE_CYCLES))
        cnt <= cnt + 8'd1;
      for (int k = 0; k < 4; k++)
        if (capture && sel_oh[k]) shadow[4*k +: 4] <= dec_val;
      cap   <= cap_nxt;
      bad   <= bad_nxt;
      valid <= 1'b0;
      if (cap == 4'hF) begin
        digits    <= shadow;
        valid     <= 1'b1;
        frame_err <= |bad;
`ifdef SSG_SCAN_RX_ERRCNT_EN
        if (|bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ssg_scan_rx.sv
// Directed bench for ssg_scan_rx: table of scan patterns plus reset/latency/masking sequences.
module tb_ssg_scan_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic        valid, frame_err;
`ifdef SSG_SCAN_RX_ERRCNT_EN
  logic [7:0]  err_count;
  int          exp_ec;
`endif

  ssg_scan_rx #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
    .digits(digits), .valid(valid), .frame_err(frame_err)
`ifdef SSG_SCAN_RX_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int npass = 0, ntot = 0;
  int vcnt;
  logic [15:0] last_dig, first_dig;
  logic        last_err;

  always @(negedge clk) if (valid) begin
    if (vcnt == 0) first_dig = digits;
    vcnt     = vcnt + 1;
    last_dig = digits;
    last_err = frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'b1111110; 4'h1: p = 7'b0110000; 4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001; 4'h4: p = 7'b0110011; 4'h5: p = 7'b1011011;
      4'h6: p = 7'b0011111; 4'h7: p = 7'b1110000; 4'h8: p = 7'b1111111;
      4'h9: p = 7'b1110011; 4'hE: p = 7'b1001111;
      default: p = 7'b0000000;
    endcase
    return ~p;
  endfunction

  task automatic show(input int k, input logic [3:0] d, input int dwell, input int gap);
    logic [3:0] oh;
    oh    = 4'b0001 << k;
    an_n  = ~oh;
    seg_n = seg_of(d);
    cyc(dwell);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    cyc(gap);
  endtask

  task automatic scan(input logic [15:0] pat, input int dwell, input int gap);
    for (int k = 3; k >= 0; k--) show(k, pat[4*k +: 4], dwell, gap);
  endtask

  typedef struct {
    logic [15:0] pat;
    int          dwell;
    int          scans;
    int          nvalid;
    logic [15:0] exp_dig;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'h3021, 8, 1,  1, 16'h3021, 1'b0};
    tbl[1] = '{16'h3F21, 8, 1,  1, 16'h3F21, 1'b1};
    tbl[2] = '{16'h4567, 8, 2,  2, 16'h4567, 1'b0};
    tbl[3] = '{16'h89E0, 6, 1,  1, 16'h89F0, 1'b1};
    tbl[4] = '{16'h1234, 3, 10, 0, 16'h89F0, 1'b1};
    tbl[5] = '{16'h5678, 4, 1,  1, 16'h5678, 1'b0};

    vcnt  = 0;
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    cyc(3);
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
`ifdef SSG_SCAN_RX_ERRCNT_EN
    exp_ec = 0;
    chk("reset_errcnt", 32'(err_count), 32'h0);
`endif
    rst_n = 1'b1;
    cyc(4);
    chk("post_reset_no_valid", 32'(vcnt), 32'h0);

    foreach (tbl[i]) begin
      vcnt = 0;
      for (int s = 0; s < tbl[i].scans; s++) scan(tbl[i].pat, tbl[i].dwell, 2);
      cyc(8);
      chk($sformatf("vec%0d_nvalid", i), 32'(vcnt), 32'(tbl[i].nvalid));
      chk($sformatf("vec%0d_digits", i), 32'(digits), 32'(tbl[i].exp_dig));
      chk($sformatf("vec%0d_err", i), 32'(frame_err), 32'(tbl[i].exp_err));
`ifdef SSG_SCAN_RX_ERRCNT_EN
      if (tbl[i].exp_err) exp_ec += tbl[i].nvalid;
      chk($sformatf("vec%0d_errcnt", i), 32'(err_count), 32'(exp_ec));
`endif
    end

    // Two enables low must not capture or disturb the partial frame; then exact latency.
    vcnt = 0;
    show(3, 4'h7, 8, 2);
    show(2, 4'h8, 8, 2);
    show(1, 4'h9, 8, 2);
    an_n  = 4'b1010;
    seg_n = seg_of(4'h3);
    cyc(20);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    cyc(2);
    chk("multi_en_no_valid", 32'(vcnt), 32'h0);
    an_n  = 4'b1110;
    seg_n = seg_of(4'h0);
    repeat (6) @(posedge clk);
    #1 chk("latency_early", 32'(valid), 32'h0);
    @(posedge clk);
    #1 chk("latency_valid", 32'(valid), 32'h1);
    chk("latency_digits", 32'(digits), 32'h7890);
    @(posedge clk);
    #1 chk("valid_one_cycle", 32'(valid), 32'h0);
    cyc(6);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    cyc(4);
    chk("multi_en_total_valid", 32'(vcnt), 32'h1);

    // Reset with a partial frame pending discards it.
    vcnt = 0;
    show(3, 4'h1, 8, 2);
    show(2, 4'h2, 8, 2);
    show(1, 4'h3, 8, 2);
    rst_n = 1'b0;
    cyc(3);
    chk("midreset_valid", 32'(valid), 32'h0);
    chk("midreset_digits", 32'(digits), 32'h0);
    rst_n = 1'b1;
    cyc(6);
    chk("after_reset_no_valid", 32'(vcnt), 32'h0);
    scan(16'h9999, 8, 2);
    cyc(8);
    chk("reset_first_valid", 32'(first_dig), 32'h9999);
    chk("reset_nvalid", 32'(vcnt), 32'h1);
    chk("reset_err_clear", 32'(last_err), 32'h0);

`ifdef SSG_SCAN_RX_ERRCNT_EN
    chk("errcnt_after_reset", 32'(err_count), 32'h0);
    vcnt = 0;
    for (int f = 0; f < 256; f++) scan(16'hFFFF, 4, 1);
    cyc(8);
    chk("sat_nvalid", 32'(vcnt), 32'd256);
    chk("errcnt_saturate", 32'(err_count), 32'd255);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
